lsu_mem_port: RTL and testbench

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

---
 rtl/lsu_mem_port.sv | 226 ++++++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit front end for a byte-laned single-port RAM.
// Accepts one request at a time, performs B/H/W accesses with store-lane
// replication and load lane extraction plus sign/zero extension.
// Optional feature macro: LSU_MISALIGN_SPLIT_EN. When it is defined, misaligned
// H/W accesses are split into sequential byte accesses. When it is undefined,
// they complete with resp_err=1.
module lsu_mem_port (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [2:0]  mem_mode,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

`ifdef LSU_MISALIGN_SPLIT_EN
    typedef enum logic [1:0] {StIdle, StAccess, StSplit, StResp} state_e;
`else
    typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;
`endif

    localparam logic [2:0] ModeNone = 3'b000;
    localparam logic [2:0] ModeSb   = 3'b001;
    localparam logic [2:0] ModeSh   = 3'b010;
    localparam logic [2:0] ModeSw   = 3'b011;

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  f3_q, f3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

`ifdef LSU_MISALIGN_SPLIT_EN
    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] asm_q, asm_d;
    logic [31:0] asm_next;
    logic [31:0] byte_addr;
    logic [7:0]  byte_rd;
    logic [1:0]  last_idx;
    logic        byte_step;
`endif

    logic is_byte, is_half, is_word;
    logic supported, aligned;

    // Sign/zero extension of a right-aligned raw load value.
    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] f3);
        logic [31:0] r;
        case (f3)
            3'b000:  r = {{24{raw[7]}}, raw[7:0]};
            3'b001:  r = {{16{raw[15]}}, raw[15:0]};
            3'b100:  r = {24'h0, raw[7:0]};
            3'b101:  r = {16'h0, raw[15:0]};
            default: r = raw;
        endcase
        return r;
    endfunction

    // Width, legality and alignment decode of the latched request.
    always_comb begin
        is_byte   = (f3_q[1:0] == 2'b00);
        is_half   = (f3_q[1:0] == 2'b01);
        is_word   = (f3_q == 3'b010);
        // Unsigned widths exist only for loads; 011/110/111 are never legal.
        supported = (f3_q == 3'b000) || (f3_q == 3'b001) || (f3_q == 3'b010) ||
                    (!we_q && ((f3_q == 3'b100) || (f3_q == 3'b101)));
        aligned   = is_byte || (is_half && !addr_q[0]) || (is_word && (addr_q[1:0] == 2'b00));
    end

    // State and request/response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
`ifdef LSU_MISALIGN_SPLIT_EN
            cnt_q   <= 2'd0;
            asm_q   <= 32'h0;
`endif
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            f3_q    <= f3_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
`ifdef LSU_MISALIGN_SPLIT_EN
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
`endif
        end
    end

    // Next-state, memory port drive and load result formation.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        f3_d        = f3_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        req_ready   = 1'b0;
        resp_valid  = 1'b0;
        resp_rdata  = 32'h0;
        resp_err    = 1'b0;
        mem_mode    = ModeNone;
        mem_address = 32'h0;
        mem_wdata   = 32'h0;
`ifdef LSU_MISALIGN_SPLIT_EN
        cnt_d       = cnt_q;
        asm_d       = asm_q;
        byte_step   = 1'b0;
        last_idx    = is_word ? 2'd3 : 2'd1;
        byte_addr   = addr_q + {30'h0, cnt_q};
        byte_rd     = 8'(mem_rdata >> {byte_addr[1:0], 3'b000});
        asm_next    = asm_q;
        asm_next[{cnt_q, 3'b000} +: 8] = byte_rd;
`endif

        unique case (state_q)
            StIdle: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    we_d    = req_we;
                    f3_d    = req_funct3;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
`ifdef LSU_MISALIGN_SPLIT_EN
                    cnt_d   = 2'd0;
                    asm_d   = 32'h0;
`endif
                    state_d = StAccess;
                end
            end

            StAccess: begin
                if (supported && aligned) begin
                    mem_address = addr_q;
                    err_d       = 1'b0;
                    if (we_q) begin
                        rdata_d = 32'h0;
                        if (is_byte) begin
                            mem_mode  = ModeSb;
                            mem_wdata = {4{wdata_q[7:0]}};
                        end else if (is_half) begin
                            mem_mode  = ModeSh;
                            mem_wdata = {2{wdata_q[15:0]}};
                        end else begin
                            mem_mode  = ModeSw;
                            mem_wdata = wdata_q;
                        end
                    end else begin
                        rdata_d = extend(mem_rdata >> {addr_q[1:0], 3'b000}, f3_q);
                    end
                    state_d = StResp;
`ifdef LSU_MISALIGN_SPLIT_EN
                end else if (supported) begin
                    // First byte of a split access; the rest continue in StSplit.
                    byte_step = 1'b1;
                    err_d     = 1'b0;
`endif
                end else begin
                    // Rejected: no RAM write, error response with zero data.
                    err_d   = 1'b1;
                    rdata_d = 32'h0;
                    state_d = StResp;
                end
            end

`ifdef LSU_MISALIGN_SPLIT_EN
            StSplit: begin
                byte_step = 1'b1;
            end
`endif

            StResp: begin
                resp_valid = 1'b1;
                resp_rdata = rdata_q;
                resp_err   = err_q;
                state_d    = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

`ifdef LSU_MISALIGN_SPLIT_EN
        // One byte of a split access at addr+cnt; address wraps naturally.
        if (byte_step) begin
            mem_address = byte_addr;
            if (we_q) begin
                mem_mode  = ModeSb;
                mem_wdata = {4{8'(wdata_q >> {cnt_q, 3'b000})}};
            end else begin
                asm_d = asm_next;
            end
            if (cnt_q == last_idx) begin
                rdata_d = we_q ? 32'h0 : extend(asm_next, f3_q);
                state_d = StResp;
            end else begin
                cnt_d   = cnt_q + 2'd1;
                state_d = StSplit;
            end
        end
`endif
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Self-checking bench for lsu_mem_port: table-driven directed vectors against a
// behavioural byte-laned RAM, plus hand-written reset-abort and held-request
// sequences. Split-mode vectors are used when LSU_MISALIGN_SPLIT_EN is defined.
module tb_lsu_mem_port;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [2:0]  mem_mode;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int n_vec;
    int n_bad;

    logic [31:0] ram [0:63];

    lsu_mem_port dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_funct3  (req_funct3),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .resp_valid  (resp_valid),
        .resp_rdata  (resp_rdata),
        .resp_err    (resp_err),
        .mem_mode    (mem_mode),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural RAM: combinational read, lane writes on the rising edge.
    assign mem_rdata = ram[mem_address[7:2]];

    always @(posedge clk) begin
        case (mem_mode)
            3'b001: ram[mem_address[7:2]][{mem_address[1:0], 3'b000} +: 8] <= 
                        mem_wdata[{mem_address[1:0], 3'b000} +: 8];
            3'b010: ram[mem_address[7:2]][{mem_address[1], 4'b0000} +: 16] <=
                        mem_wdata[{mem_address[1], 4'b0000} +: 16];
            3'b011: ram[mem_address[7:2]] <= mem_wdata;
            default: ;
        endcase
    end

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        logic [2:0]  exp_mode;
        logic [31:0] exp_wdata;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp_rdata,
                                input logic exp_err, input logic [2:0] exp_mode,
                                input logic [31:0] exp_wdata, input int exp_lat);
        vec_t v;
        v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = exp_rdata; v.exp_err = exp_err; v.exp_mode = exp_mode;
        v.exp_wdata = exp_wdata; v.exp_lat = exp_lat;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        bit got;
        @(negedge clk);
        check($sformatf("v%0d_ready", idx), {31'h0, req_ready}, 32'h1);
        req_valid  = 1'b1;
        req_we     = v.we;
        req_funct3 = v.f3;
        req_addr   = v.addr;
        req_wdata  = v.wdata;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check($sformatf("v%0d_mode", idx), {29'h0, mem_mode}, {29'h0, v.exp_mode});
        if (!v.exp_err) check($sformatf("v%0d_addr", idx), mem_address, v.addr);
        if (v.we && !v.exp_err) check($sformatf("v%0d_wdata", idx), mem_wdata, v.exp_wdata);
        lat = 1;
        got = 1'b0;
        while (!got && lat < 10) begin
            if (resp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        check($sformatf("v%0d_latency", idx), lat, v.exp_lat);
        check($sformatf("v%0d_rdata", idx), resp_rdata, v.exp_rdata);
        check($sformatf("v%0d_err", idx), {31'h0, resp_err}, {31'h0, v.exp_err});
    endtask

    initial begin
        int k_first;
        int k_second;
        n_vec = 0;
        n_bad = 0;
        for (int i = 0; i < 64; i++) ram[i] = 32'h0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;

        // Aligned traffic and illegal-width rejection.
        vecs.push_back(mk(1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 3'b011, 32'hDEADBEEF, 2));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 3'b000, 32'h0, 2));
        vecs.push_back(mk(1, 3'b000, 32'h13, 32'h80, 32'h0, 0, 3'b001, 32'h80808080, 2));
        vecs.push_back(mk(0, 3'b000, 32'h13, 32'h0, 32'hFFFFFF80, 0, 3'b000, 32'h0, 2));
        vecs.push_back(mk(0, 3'b100, 32'h13, 32'h0, 32'h00000080, 0, 3'b000, 32'h0, 2));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0, 3'b000, 32'h0, 2));
        vecs.push_back(mk(1, 3'b001, 32'h22, 32'h1234, 32'h0, 0, 3'b010, 32'h12341234, 2));
        vecs.push_back(mk(0, 3'b101, 32'h22, 32'h0, 32'h00001234, 0, 3'b000, 32'h0, 2));
        vecs.push_back(mk(1, 3'b001, 32'h20, 32'hBEEF, 32'h0, 0, 3'b010, 32'hBEEFBEEF, 2));
        vecs.push_back(mk(0, 3'b001, 32'h20, 32'h0, 32'hFFFFBEEF, 0, 3'b000, 32'h0, 2));
        vecs.push_back(mk(0, 3'b101, 32'h20, 32'h0, 32'h0000BEEF, 0, 3'b000, 32'h0, 2));
        vecs.push_back(mk(0, 3'b000, 32'h21, 32'h0, 32'hFFFFFFBE, 0, 3'b000, 32'h0, 2));
        vecs.push_back(mk(0, 3'b100, 32'h22, 32'h0, 32'h00000034, 0, 3'b000, 32'h0, 2));
        vecs.push_back(mk(0, 3'b011, 32'h10, 32'h0, 32'h0, 1, 3'b000, 32'h0, 2));
        vecs.push_back(mk(1, 3'b100, 32'h10, 32'h55, 32'h0, 1, 3'b000, 32'h0, 2));
        vecs.push_back(mk(0, 3'b110, 32'h10, 32'h0, 32'h0, 1, 3'b000, 32'h0, 2));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0, 3'b000, 32'h0, 2));
`ifdef LSU_MISALIGN_SPLIT_EN
        vecs.push_back(mk(1, 3'b010, 32'h10, 32'h44332211, 32'h0, 0, 3'b011, 32'h44332211, 2));
        vecs.push_back(mk(1, 3'b010, 32'h14, 32'h88776655, 32'h0, 0, 3'b011, 32'h88776655, 2));
        vecs.push_back(mk(0, 3'b010, 32'h11, 32'h0, 32'h55443322, 0, 3'b000, 32'h0, 5));
        vecs.push_back(mk(0, 3'b010, 32'h13, 32'h0, 32'h77665544, 0, 3'b000, 32'h0, 5));
        vecs.push_back(mk(0, 3'b001, 32'h13, 32'h0, 32'h00005544, 0, 3'b000, 32'h0, 3));
        vecs.push_back(mk(1, 3'b001, 32'h15, 32'hABCD, 32'h0, 0, 3'b001, 32'hCDCDCDCD, 3));
        vecs.push_back(mk(0, 3'b010, 32'h14, 32'h0, 32'h88ABCD55, 0, 3'b000, 32'h0, 2));
        vecs.push_back(mk(0, 3'b001, 32'h15, 32'h0, 32'hFFFFABCD, 0, 3'b000, 32'h0, 3));
        vecs.push_back(mk(1, 3'b001, 32'hFFFFFFFF, 32'h5AA5, 32'h0, 0, 3'b001, 32'hA5A5A5A5, 3));
        vecs.push_back(mk(0, 3'b100, 32'hFFFFFFFF, 32'h0, 32'h000000A5, 0, 3'b000, 32'h0, 2));
        vecs.push_back(mk(0, 3'b100, 32'h00000000, 32'h0, 32'h0000005A, 0, 3'b000, 32'h0, 2));
`else
        vecs.push_back(mk(0, 3'b010, 32'h11, 32'h0, 32'h0, 1, 3'b000, 32'h0, 2));
        vecs.push_back(mk(1, 3'b010, 32'h12, 32'h11111111, 32'h0, 1, 3'b000, 32'h0, 2));
        vecs.push_back(mk(1, 3'b001, 32'h23, 32'h7777, 32'h0, 1, 3'b000, 32'h0, 2));
        vecs.push_back(mk(0, 3'b001, 32'h21, 32'h0, 32'h0, 1, 3'b000, 32'h0, 2));
        vecs.push_back(mk(0, 3'b010, 32'h10, 32'h0, 32'h80ADBEEF, 0, 3'b000, 32'h0, 2));
        vecs.push_back(mk(0, 3'b010, 32'h20, 32'h0, 32'h1234BEEF, 0, 3'b000, 32'h0, 2));
`endif

        // Reset state.
        #12;
        check("rst_ready", {31'h0, req_ready}, 32'h1);
        check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
        check("rst_mem_mode", {29'h0, mem_mode}, 32'h0);
        check("rst_mem_address", mem_address, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i], i);

        // Reset asserted during the ACCESS cycle of a store: abandon, no write.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'b010;
        req_addr   = 32'h30;
        req_wdata  = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("abort_mode_before", {29'h0, mem_mode}, 32'h3);
        rst_n = 1'b0;
        #1;
        check("abort_mode", {29'h0, mem_mode}, 32'h0);
        check("abort_address", mem_address, 32'h0);
        check("abort_wdata", mem_wdata, 32'h0);
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        check("abort_resp_valid", {31'h0, resp_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("abort_ready_after", {31'h0, req_ready}, 32'h1);
        run_vec(mk(0, 3'b010, 32'h30, 32'h0, 32'h0, 0, 3'b000, 32'h0, 2), 100);

        // Request held high across RESP: next acceptance waits for IDLE.
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h10;
        k_first  = -1;
        k_second = -1;
        for (int k = 1; k < 12; k++) begin
            @(negedge clk);
            if (resp_valid) begin
                if (k_first < 0) k_first = k;
                else if (k_second < 0) k_second = k;
                check($sformatf("hold_ready_in_resp_k%0d", k), {31'h0, req_ready}, 32'h0);
            end
        end
        req_valid = 1'b0;
        check("hold_first_resp", k_first, 2);
        check("hold_resp_gap", k_second - k_first, 3);

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
